pipeline_wb_scoreboard: RTL and testbench

//  Writer side of the pipeline register file. Takes retiring instructions from MEM through a valid/ready handshake.

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/pipeline_wb_scoreboard_load_extend.sv | 36 +++
 rtl/pipeline_wb_scoreboard.sv | 161 ++++++++++++++++
 tb/tb_pipeline_wb_scoreboard.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
//   Shared types and constants for the writeback stage.
//   - XLEN        : datapath width
//   - wb_sel_e    : writeback result select (ALU, LOAD, PC4, IMM)
//   - F3_*        : load funct3 encodings understood by load_extend
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_IMM  = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/pipeline_wb_scoreboard_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
//   Combinational load formatter: selects the byte/half addressed by
//   addr_lo_i out of the raw word and sign- or zero-extends it.
//   Ports:
//     funct3_i  [2:0]  load type (LB/LH/LW/LBU/LHU, others -> full word)
//     addr_lo_i [1:0]  byte offset within the word
//     rdata_i   [31:0] raw load word
//     result_o  [31:0] formatted load value
// ---------------------------------------------------------------------------
module load_extend
    import pipeline_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        byte_w = rdata_i[{addr_lo_i, 3'b000} +: 8];
        // Halfword lanes are chosen by addr_lo[1] only; addr_lo[0] is ignored.
        half_w = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_LB:   result_o = {{24{byte_w[7]}}, byte_w};
            F3_LH:   result_o = {{16{half_w[15]}}, half_w};
            F3_LBU:  result_o = {24'd0, byte_w};
            F3_LHU:  result_o = {16'd0, half_w};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/pipeline_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// pipeline_wb_scoreboard
//   Writeback stage: accepts retiring instructions from MEM, formats load
//   data, drives the register-file write port, tracks in-flight writes per
//   register to stall ID on RAW hazards, and counts retired instructions.
//   Ports:
//     clk, reset (sync, active-low)
//     mem_valid/mem_ready + mem_* fields : retiring instruction from MEM
//     dmem_rvalid, dmem_rdata            : load data return
//     id_issue, id_regwrite, id_rd       : instruction leaving ID
//     id_rs1, id_rs2, id_stall           : hazard check for ID
//     rd_we, rd_addr, rd_data            : register-file write port
//     instret                            : 64-bit retired count
//
// Handshake: a transfer happens on a posedge where mem_valid && mem_ready.
// mem_ready depends only on WB state and dmem_rvalid, never on mem_valid,
// so MEM may hold mem_valid and its fields until the transfer occurs.
// ---------------------------------------------------------------------------
module pipeline_wb_scoreboard
    import pipeline_pkg::*;
#(
    parameter int PEND_W = 2,
    parameter int NREGS  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [1:0]      mem_wb_sel,
    input  logic [2:0]      mem_funct3,
    input  logic [1:0]      mem_addr_lo,
    input  logic [XLEN-1:0] mem_alu,
    input  logic [XLEN-1:0] mem_pc4,
    input  logic [XLEN-1:0] mem_imm,
    input  logic            mem_regwrite,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            id_issue,
    input  logic            id_regwrite,
    input  logic [4:0]      id_rd,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    output logic            id_stall,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic [63:0]     instret
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic            wb_valid_q;
    logic            wb_regwrite_q;
    logic [4:0]      wb_rd_q;
    wb_sel_e         wb_sel_q;
    logic [2:0]      wb_funct3_q;
    logic [1:0]      wb_addr_lo_q;
    logic [XLEN-1:0] wb_alu_q;
    logic [XLEN-1:0] wb_pc4_q;
    logic [XLEN-1:0] wb_imm_q;
    logic [PEND_W-1:0] cnt_q [NREGS];
    logic [PEND_W-1:0] cnt_d [NREGS];
    logic [63:0]     instret_q;
    logic [63:0]     instret_d;

    logic            done;
    logic            accept;
    logic            rs1_hz;
    logic            rs2_hz;
    logic            issue_ok;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] result;

    load_extend u_load_extend (
        .funct3_i  (wb_funct3_q),
        .addr_lo_i (wb_addr_lo_q),
        .rdata_i   (dmem_rdata),
        .result_o  (load_val)
    );

    always_comb begin
        // Gating with reset keeps every output quiet while reset is held,
        // even if an entry was valid when reset arrived.
        done      = reset && wb_valid_q && (wb_sel_q != WB_LOAD || dmem_rvalid);
        mem_ready = reset && (!wb_valid_q || done);
        accept    = mem_valid && mem_ready;

        case (wb_sel_q)
            WB_ALU:  result = wb_alu_q;
            WB_LOAD: result = load_val;
            WB_PC4:  result = wb_pc4_q;
            default: result = wb_imm_q;
        endcase

        rd_we   = done && wb_regwrite_q && (wb_rd_q != 5'd0);
        rd_addr = reset ? wb_rd_q : 5'd0;
        rd_data = done ? result : '0;

        // A source whose last pending write is retiring now does not stall:
        // the register file writes at the negedge, before ID reads it.
        rs1_hz = (id_rs1 != 5'd0) && (cnt_q[id_rs1] != '0) &&
                 !(rd_we && wb_rd_q == id_rs1 && cnt_q[id_rs1] == CNT_ONE);
        rs2_hz = (id_rs2 != 5'd0) && (cnt_q[id_rs2] != '0) &&
                 !(rd_we && wb_rd_q == id_rs2 && cnt_q[id_rs2] == CNT_ONE);
        id_stall = reset && (rs1_hz || rs2_hz ||
                             (id_regwrite && cnt_q[id_rd] == CNT_MAX));

        issue_ok = id_issue && id_regwrite && !id_stall && (id_rd != 5'd0);

        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue_ok && id_rd == 5'(r) && !(rd_we && wb_rd_q == 5'(r))) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (rd_we && wb_rd_q == 5'(r) && !(issue_ok && id_rd == 5'(r)) &&
                         cnt_q[r] != '0) begin
                // An unmatched retire on an idle counter saturates at zero.
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end

        instret_d = instret_q + 64'(done);
        instret   = instret_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_sel_q      <= WB_ALU;
            wb_funct3_q   <= 3'd0;
            wb_addr_lo_q  <= 2'd0;
            wb_alu_q      <= '0;
            wb_pc4_q      <= '0;
            wb_imm_q      <= '0;
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
            instret_q     <= 64'd0;
        end else begin
            if (accept) begin
                wb_valid_q    <= 1'b1;
                wb_regwrite_q <= mem_regwrite;
                wb_rd_q       <= mem_rd;
                wb_sel_q      <= wb_sel_e'(mem_wb_sel);
                wb_funct3_q   <= mem_funct3;
                wb_addr_lo_q  <= mem_addr_lo;
                wb_alu_q      <= mem_alu;
                wb_pc4_q      <= mem_pc4;
                wb_imm_q      <= mem_imm;
            end else if (done) begin
                wb_valid_q    <= 1'b0;
            end
            cnt_q     <= cnt_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_pipeline_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_pipeline_wb_scoreboard
//   Directed scenarios with literal expectations, then randomized traffic.
//   A transaction-level model (queue of in-flight WB entries, integer
//   pending counts per register, a retire counter) predicts every output
//   on each negedge.
// ---------------------------------------------------------------------------
module tb_pipeline_wb_scoreboard;

    localparam int PEND_W = 2;
    localparam int PMAX   = 3;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu, mem_pc4, mem_imm;
    logic        mem_regwrite;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        id_issue, id_regwrite;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic        id_stall;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [63:0] instret;

    always #5 clk = ~clk;

    pipeline_wb_scoreboard #(.PEND_W(PEND_W), .NREGS(32)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
        .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
        .mem_alu(mem_alu), .mem_pc4(mem_pc4), .mem_imm(mem_imm),
        .mem_regwrite(mem_regwrite), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .id_issue(id_issue), .id_regwrite(id_regwrite), .id_rd(id_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_stall(id_stall),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data), .instret(instret)
    );

    // ---------------- counters / check ----------------
    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic        we;
    } instr_t;

    instr_t      wb_q[$];
    int          pend[32];
    logic [63:0] m_instret = 64'd0;
    bit          mdl_on = 1'b0;
    instr_t      m_e;
    bit          m_busy, m_fin, m_ready, m_we, m_stall;
    logic [31:0] m_data;
    int          inc_r, dec_r;

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit hz(input logic [4:0] rs);
        return rs != 0 && pend[rs] > 0 && !(m_we && m_e.rd == rs && pend[rs] == 1);
    endfunction

    always @(negedge clk) begin
        if (mdl_on) begin
            if (!reset) begin
                chk("rst_ready", 64'(mem_ready), 64'd0);
                chk("rst_we", 64'(rd_we), 64'd0);
                chk("rst_addr", 64'(rd_addr), 64'd0);
                chk("rst_data", 64'(rd_data), 64'd0);
                chk("rst_stall", 64'(id_stall), 64'd0);
                chk("rst_instret", instret, m_instret);
                wb_q.delete();
                foreach (pend[i]) pend[i] = 0;
                m_instret = 64'd0;
            end else begin
                m_busy = wb_q.size() != 0;
                if (m_busy) m_e = wb_q[0];
                m_fin   = m_busy && (m_e.sel != 2'd1 || dmem_rvalid);
                m_ready = !m_busy || m_fin;
                m_we    = m_fin && m_e.we && m_e.rd != 0;
                m_data  = 32'd0;
                if (m_fin) begin
                    case (m_e.sel)
                        2'd0: m_data = m_e.alu;
                        2'd1: m_data = model_load(m_e.f3, m_e.off, dmem_rdata);
                        2'd2: m_data = m_e.pc4;
                        default: m_data = m_e.imm;
                    endcase
                end
                m_stall = hz(id_rs1) || hz(id_rs2) || (id_regwrite && pend[id_rd] == PMAX);

                chk("mdl_ready", 64'(mem_ready), 64'(m_ready));
                chk("mdl_we", 64'(rd_we), 64'(m_we));
                chk("mdl_data", 64'(rd_data), 64'(m_data));
                chk("mdl_stall", 64'(id_stall), 64'(m_stall));
                chk("mdl_instret", instret, m_instret);
                if (m_busy) chk("mdl_addr", 64'(rd_addr), 64'(m_e.rd));

                inc_r = (id_issue && id_regwrite && !m_stall && id_rd != 0) ? int'(id_rd) : -1;
                dec_r = m_we ? int'(m_e.rd) : -1;
                if (inc_r != dec_r) begin
                    if (inc_r >= 0) pend[inc_r]++;
                    if (dec_r >= 0 && pend[dec_r] > 0) pend[dec_r]--;
                end
                if (m_fin) begin
                    m_instret++;
                    void'(wb_q.pop_front());
                end
                if (mem_valid && m_ready)
                    wb_q.push_back('{mem_rd, mem_wb_sel, mem_funct3, mem_addr_lo,
                                     mem_alu, mem_pc4, mem_imm, mem_regwrite});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid = 0; mem_rd = 0; mem_wb_sel = 0; mem_funct3 = 0; mem_addr_lo = 0;
        mem_alu = 0; mem_pc4 = 0; mem_imm = 0; mem_regwrite = 0;
        dmem_rvalid = 0; dmem_rdata = 0;
        id_issue = 0; id_regwrite = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        idle();
        step();
        mdl_on = 1'b1;
        step();
        reset = 1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] v);
        mem_valid = 1; mem_wb_sel = sel; mem_rd = rd; mem_regwrite = 1;
        mem_alu = v; mem_pc4 = v; mem_imm = v;
    endtask

    task automatic issue(input logic [4:0] rd);
        id_issue = 1; id_regwrite = 1; id_rd = rd;
    endtask

    task automatic load_case(input string nm, input logic [2:0] f3, input logic [1:0] off,
                             input logic [31:0] w, input logic [31:0] exp);
        send(2'd1, 5'd6, 32'd0);
        mem_funct3 = f3; mem_addr_lo = off;
        step();
        mem_valid = 0;
        dmem_rvalid = 1; dmem_rdata = w;
        @(negedge clk);
        chk(nm, 64'(rd_data), 64'(exp));
        step();
        dmem_rvalid = 0;
    endtask

    task automatic rand_mem();
        mem_valid    = ($urandom_range(0, 3) != 0);
        mem_rd       = 5'($urandom_range(0, 7));
        mem_wb_sel   = 2'($urandom_range(0, 3));
        mem_funct3   = 3'($urandom_range(0, 7));
        mem_addr_lo  = 2'($urandom_range(0, 3));
        mem_alu      = $urandom;
        mem_pc4      = $urandom;
        mem_imm      = $urandom;
        mem_regwrite = ($urandom_range(0, 4) != 0);
    endtask

    // ---------------- stimulus ----------------
    bit acc;

    initial begin
        reset = 0;
        idle();
        do_reset();

        // 1: ALU op
        send(2'd0, 5'd5, 32'h1234);
        @(negedge clk); chk("t1_ready", 64'(mem_ready), 64'd1);
        step();
        mem_valid = 0;
        @(negedge clk);
        chk("t1_we", 64'(rd_we), 64'd1);
        chk("t1_addr", 64'(rd_addr), 64'd5);
        chk("t1_data", 64'(rd_data), 64'h1234);
        step();
        @(negedge clk);
        chk("t1_instret", instret, 64'd1);
        chk("t1_we_off", 64'(rd_we), 64'd0);

        // 2: LB with data delayed 3 cycles
        send(2'd1, 5'd6, 32'd0);
        mem_funct3 = 3'd0; mem_addr_lo = 2'd3;
        step();
        mem_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_wait_ready", 64'(mem_ready), 64'd0);
            chk("t2_wait_we", 64'(rd_we), 64'd0);
            step();
        end
        dmem_rvalid = 1; dmem_rdata = 32'h80FF_0000;
        @(negedge clk);
        chk("t2_lb_we", 64'(rd_we), 64'd1);
        chk("t2_lb_data", 64'(rd_data), 64'hFFFF_FF80);
        chk("t2_lb_ready", 64'(mem_ready), 64'd1);
        step();
        dmem_rvalid = 0;
        load_case("t2_lbu", 3'd4, 2'd3, 32'h80FF_0000, 32'h0000_0080);
        load_case("t2_lh",  3'd1, 2'd2, 32'h8001_1234, 32'hFFFF_8001);
        load_case("t2_lhu", 3'd5, 2'd2, 32'h8001_1234, 32'h0000_8001);
        load_case("t2_lh0", 3'd1, 2'd0, 32'h8001_1234, 32'h0000_1234);
        load_case("t2_lb1", 3'd0, 2'd1, 32'h8001_1234, 32'h0000_0012);
        load_case("t2_lb0", 3'd0, 2'd0, 32'h0000_00F0, 32'hFFFF_FFF0);
        load_case("t2_lw",  3'd2, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load_case("t2_f3x", 3'd7, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // PC4 / IMM selects
        send(2'd2, 5'd8, 32'h0000_0104);
        step();
        send(2'd3, 5'd8, 32'hABCD_E000);
        @(negedge clk); chk("pc4_data", 64'(rd_data), 64'h104);
        step();
        mem_valid = 0;
        @(negedge clk); chk("imm_data", 64'(rd_data), 64'hABCD_E000);
        step();

        // 3: RAW on rd=7 with two pending writes
        do_reset();
        issue(5'd7);
        @(negedge clk); chk("t3_iss1", 64'(id_stall), 64'd0);
        step();
        @(negedge clk); chk("t3_iss2", 64'(id_stall), 64'd0);
        step();
        idle();
        id_rs1 = 5'd7;
        send(2'd0, 5'd7, 32'h77);
        @(negedge clk); chk("t3_stall_a", 64'(id_stall), 64'd1);
        step();
        @(negedge clk); chk("t3_stall_b", 64'(id_stall), 64'd1);
        step();
        mem_valid = 0;
        @(negedge clk);
        chk("t3_last_we", 64'(rd_we), 64'd1);
        chk("t3_bypass", 64'(id_stall), 64'd0);
        step();
        @(negedge clk); chk("t3_clear", 64'(id_stall), 64'd0);

        // 4: counter full on rd=9
        do_reset();
        issue(5'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("t4_issue", 64'(id_stall), 64'd0);
            step();
        end
        @(negedge clk); chk("t4_full", 64'(id_stall), 64'd1);
        step();
        id_issue = 0;
        send(2'd0, 5'd9, 32'h9);
        @(negedge clk); chk("t4_still_full", 64'(id_stall), 64'd1);
        step();
        mem_valid = 0;
        @(negedge clk); chk("t4_retire_cycle", 64'(id_stall), 64'd1);
        step();
        @(negedge clk); chk("t4_room", 64'(id_stall), 64'd0);
        step();

        // 5: issue and retire rd=4 in one cycle; write to x0
        do_reset();
        issue(5'd4);
        step();
        idle();
        send(2'd0, 5'd4, 32'h44);
        step();
        mem_valid = 0;
        issue(5'd4);
        @(negedge clk);
        chk("t5_we", 64'(rd_we), 64'd1);
        chk("t5_nostall", 64'(id_stall), 64'd0);
        step();
        idle();
        id_rs1 = 5'd4;
        @(negedge clk); chk("t5_cnt_kept", 64'(id_stall), 64'd1);
        send(2'd0, 5'd0, 32'h55);
        step();
        mem_valid = 0;
        @(negedge clk); chk("t5_x0_we", 64'(rd_we), 64'd0);
        step();
        @(negedge clk); chk("t5_instret", instret, 64'd2);

        // 6: reset while a load waits
        do_reset();
        send(2'd0, 5'd2, 32'h1);
        step();
        issue(5'd3);
        send(2'd1, 5'd3, 32'd0);
        step();
        idle();
        id_rs1 = 5'd3;
        @(negedge clk);
        chk("t6_wait_ready", 64'(mem_ready), 64'd0);
        chk("t6_pre_instret", instret, 64'd1);
        reset = 0;
        @(negedge clk);
        chk("t6_rst_ready", 64'(mem_ready), 64'd0);
        chk("t6_rst_stall", 64'(id_stall), 64'd0);
        step();
        @(negedge clk);
        chk("t6_instret0", instret, 64'd0);
        chk("t6_we0", 64'(rd_we), 64'd0);
        step();
        reset = 1;
        @(negedge clk);
        chk("t6_ready", 64'(mem_ready), 64'd1);
        chk("t6_cnt_clear", 64'(id_stall), 64'd0);
        chk("t6_no_write", 64'(rd_we), 64'd0);
        step();

        // randomized traffic
        rand_mem();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            acc = mem_valid && mem_ready;
            step();
            if (!mem_valid || acc) rand_mem();
            reset       = ($urandom_range(0, 299) != 0);
            id_issue    = ($urandom_range(0, 1) != 0);
            id_regwrite = ($urandom_range(0, 3) != 0);
            id_rd       = 5'($urandom_range(0, 7));
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs2      = 5'($urandom_range(0, 7));
            dmem_rvalid = ($urandom_range(0, 2) == 0);
            dmem_rdata  = $urandom;
        end
        reset = 1;
        idle();
        step();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
